// File: rtl/ahbl_uart_rx.sv
// AHB-Lite 8N1 UART receiver: 16x oversampling, receive FIFO, status flags, interrupt.
// Define UART_RX_PARITY_EN to add an even-parity bit between the data bits and the stop bit.
module ahbl_uart_rx #(
    parameter int          FIFO_DEPTH       = 16,
    parameter logic [15:0] DEFAULT_PRESCALE = 16'd27
) (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic [2:0]  HSIZE,
    input  logic        HWRITE,
    input  logic        HREADY,
    input  logic [31:0] HWDATA,
    output logic        HREADYOUT,
    output logic [31:0] HRDATA,
    input  logic        rx,
    output logic        irq
);
    localparam int AW = $clog2(FIFO_DEPTH);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

    logic          ap_wr, ap_rd;
    logic [1:0]    ap_idx;
    logic          rx_m, rx_s, rx_d, fall;
    logic [15:0]   prescale, pcnt, pval;
    logic          tick;
    logic          en, ie, ovr, fe, pe;
    state_t        st, st_n;
    logic [3:0]    tcnt, tcnt_n;
    logic [2:0]    bcnt, bcnt_n;
    logic [7:0]    sh, sh_n;
    logic          push, fe_set, pe_set;
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW:0]   wptr, rptr;
    logic          empty, full, pop, push_ok, ovr_set;
    logic          wr_stat, wr_pre, wr_ctrl, rd_data, flush;
    logic          unused_bits;

    assign unused_bits = ^{HSIZE, HADDR[31:4], HADDR[1:0], HWDATA[31:16], HTRANS[0]};
    assign HREADYOUT = 1'b1;

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            ap_wr  <= 1'b0;
            ap_rd  <= 1'b0;
            ap_idx <= 2'd0;
        end else begin
            ap_wr <= HSEL & HREADY & HTRANS[1] & HWRITE;
            ap_rd <= HSEL & HREADY & HTRANS[1] & ~HWRITE;
            if (HSEL & HREADY & HTRANS[1]) ap_idx <= HADDR[3:2];
        end
    end

    assign wr_stat = ap_wr && ap_idx == 2'd1;
    assign wr_pre  = ap_wr && ap_idx == 2'd2;
    assign wr_ctrl = ap_wr && ap_idx == 2'd3;
    assign rd_data = ap_rd && ap_idx == 2'd0;
    assign flush   = wr_ctrl & HWDATA[1];

    assign empty   = wptr == rptr;
    assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign pop     = rd_data & ~empty;
    // A full FIFO still accepts a byte when a pop frees a slot in the same cycle.
    assign push_ok = push & (~full | pop);
    assign ovr_set = push & full & ~pop & ~flush;

    always_comb begin
        HRDATA = 32'd0;
        if (ap_rd) begin
            unique case (ap_idx)
                2'd0: if (!empty) HRDATA = {23'd0, 1'b1, mem[rptr[AW-1:0]]};
                2'd1: HRDATA = {27'd0, pe, fe, ovr, full, ~empty};
                2'd2: HRDATA = {16'd0, prescale};
                2'd3: HRDATA = {29'd0, ie, 1'b0, en};
            endcase
        end
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
            rx_d <= 1'b1;
        end else begin
            rx_m <= rx;
            rx_s <= rx_m;
            rx_d <= rx_s;
        end
    end
    assign fall = rx_d & ~rx_s;

    assign pval = (prescale == 16'd0) ? 16'd1 : prescale;
    assign tick = pcnt == pval - 16'd1;

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            prescale <= DEFAULT_PRESCALE;
            pcnt     <= 16'd0;
        end else if (wr_pre) begin
            prescale <= HWDATA[15:0];
            pcnt     <= 16'd0;
        end else begin
            pcnt <= tick ? 16'd0 : pcnt + 16'd1;
        end
    end

`ifdef UART_RX_PARITY_EN
    logic perr, perr_n;
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) perr <= 1'b0;
        else        perr <= perr_n;
    end
`endif

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            st   <= S_IDLE;
            tcnt <= 4'd0;
            bcnt <= 3'd0;
            sh   <= 8'd0;
        end else begin
            st   <= st_n;
            tcnt <= tcnt_n;
            bcnt <= bcnt_n;
            sh   <= sh_n;
        end
    end

    always_comb begin
        st_n   = st;
        tcnt_n = tcnt;
        bcnt_n = bcnt;
        sh_n   = sh;
        push   = 1'b0;
        fe_set = 1'b0;
        pe_set = 1'b0;
`ifdef UART_RX_PARITY_EN
        perr_n = perr;
`endif
        if (!en) begin
            st_n = S_IDLE;
        end else begin
            unique case (st)
                S_IDLE: if (fall) begin
                    st_n   = S_START;
                    tcnt_n = 4'd0;
                end
                S_START: if (tick) begin
                    tcnt_n = tcnt + 4'd1;
                    if (tcnt == 4'd7) begin
                        tcnt_n = 4'd0;
                        bcnt_n = 3'd0;
                        st_n   = rx_s ? S_IDLE : S_DATA;
`ifdef UART_RX_PARITY_EN
                        perr_n = 1'b0;
`endif
                    end
                end
                S_DATA: if (tick) begin
                    tcnt_n = tcnt + 4'd1;
                    if (tcnt == 4'd15) begin
                        sh_n   = {rx_s, sh[7:1]};
                        bcnt_n = bcnt + 3'd1;
`ifdef UART_RX_PARITY_EN
                        if (bcnt == 3'd7) st_n = S_PARITY;
`else
                        if (bcnt == 3'd7) st_n = S_STOP;
`endif
                    end
                end
`ifdef UART_RX_PARITY_EN
                S_PARITY: if (tick) begin
                    tcnt_n = tcnt + 4'd1;
                    if (tcnt == 4'd15) begin
                        st_n = S_STOP;
                        if (^{sh, rx_s}) begin
                            pe_set = 1'b1;
                            perr_n = 1'b1;
                        end
                    end
                end
`endif
                S_STOP: if (tick) begin
                    tcnt_n = tcnt + 4'd1;
                    if (tcnt == 4'd15) begin
                        st_n = S_IDLE;
                        if (rx_s) begin
`ifdef UART_RX_PARITY_EN
                            push = ~perr;
`else
                            push = 1'b1;
`endif
                        end else begin
                            fe_set = 1'b1;
                        end
                    end
                end
                default: st_n = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            wptr <= '0;
            rptr <= '0;
        end else if (flush) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (pop)     rptr <= rptr + 1'b1;
            if (push_ok) wptr <= wptr + 1'b1;
        end
    end

    always_ff @(posedge HCLK) begin
        if (push_ok && !flush) mem[wptr[AW-1:0]] <= sh;
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) pe <= 1'b0;
        else        pe <= pe_set | (pe & ~(wr_stat & HWDATA[4]));
    end
`else
    assign pe = 1'b0;
    logic unused_pe;
    assign unused_pe = pe_set;
`endif

    // Flag set takes priority over a simultaneous write-1-to-clear.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            ovr <= 1'b0;
            fe  <= 1'b0;
            en  <= 1'b0;
            ie  <= 1'b0;
            irq <= 1'b0;
        end else begin
            ovr <= ovr_set | (ovr & ~(wr_stat & HWDATA[2]));
            fe  <= fe_set | (fe & ~(wr_stat & HWDATA[3]));
            if (wr_ctrl) begin
                en <= HWDATA[0];
                ie <= HWDATA[2];
            end
            irq <= ie & (~empty | ovr | fe | pe);
        end
    end
endmodule

// File: tb/tb_ahbl_uart_rx.sv
// Directed bench for ahbl_uart_rx: bus register access, framing, overrun, abort and glitch cases.
// Parity cases are included when UART_RX_PARITY_EN is defined.
module tb_ahbl_uart_rx;
    logic        HCLK = 1'b0;
    logic        HRESET;
    logic        HSEL;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic [2:0]  HSIZE;
    logic        HWRITE;
    logic        HREADY;
    logic [31:0] HWDATA;
    logic        HREADYOUT;
    logic [31:0] HRDATA;
    logic        rx;
    logic        irq;

    int checks = 0;
    int errors = 0;
    logic [31:0] sb[$];
    logic [31:0] rd;

    ahbl_uart_rx dut (
        .HCLK(HCLK), .HRESET(HRESET), .HSEL(HSEL), .HADDR(HADDR),
        .HTRANS(HTRANS), .HSIZE(HSIZE), .HWRITE(HWRITE), .HREADY(HREADY),
        .HWDATA(HWDATA), .HREADYOUT(HREADYOUT), .HRDATA(HRDATA),
        .rx(rx), .irq(irq)
    );

    always #5 HCLK = ~HCLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic bus_wr(input logic [31:0] a, input logic [31:0] d);
        @(posedge HCLK); #1;
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = a;
        @(posedge HCLK); #1;
        HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HWDATA = d;
        @(posedge HCLK); #1;
    endtask

    task automatic bus_rd(input logic [31:0] a, output logic [31:0] d);
        @(posedge HCLK); #1;
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = a;
        @(posedge HCLK); #1;
        HSEL = 1'b0; HTRANS = 2'b00;
        d = HRDATA;
        @(posedge HCLK); #1;
    endtask

    task automatic bitwait();
        repeat (64) @(posedge HCLK);
        #1;
    endtask

    task automatic send(input logic [7:0] b, input logic stop, input logic par_good);
        rx = 1'b0;
        bitwait();
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            bitwait();
        end
`ifdef UART_RX_PARITY_EN
        rx = ^b ^ ~par_good;
        bitwait();
`endif
        rx = stop;
        bitwait();
        rx = 1'b1;
        bitwait();
    endtask

    task automatic rd_sb(input string tag);
        logic [31:0] exp;
        exp = (sb.size() == 0) ? 32'h0 : sb.pop_front();
        bus_rd(32'h0, rd);
        chk(tag, rd, exp);
    endtask

    initial begin
        HRESET = 1'b1; HSEL = 1'b0; HADDR = '0; HTRANS = 2'b00; HSIZE = 3'd2;
        HWRITE = 1'b0; HREADY = 1'b1; HWDATA = '0; rx = 1'b1;
        repeat (3) @(posedge HCLK);
        #1 HRESET = 1'b0;
        chk("rst_hreadyout", {31'd0, HREADYOUT}, 32'd1);
        chk("rst_hrdata", HRDATA, 32'd0);
        chk("rst_irq", {31'd0, irq}, 32'd0);
        bus_rd(32'h4, rd); chk("rst_status", rd, 32'h0);
        bus_rd(32'h8, rd); chk("rst_prescale", rd, 32'd27);
        bus_rd(32'hC, rd); chk("rst_ctrl", rd, 32'h0);

        bus_wr(32'h8, 32'd4);
        bus_wr(32'hC, 32'h1);
        bus_rd(32'h8, rd); chk("prescale_wr", rd, 32'd4);

        send(8'h55, 1'b1, 1'b1); sb.push_back(32'h155);
        bus_rd(32'h4, rd); chk("s55_status", rd, 32'h1);
        rd_sb("s55_data");
        bus_rd(32'h4, rd); chk("s55_status_after", rd, 32'h0);
        bus_rd(32'h0, rd); chk("empty_data", rd, 32'h0);

        for (int i = 0; i < 17; i++) begin
            send(8'(i), 1'b1, 1'b1);
            if (i < 16) sb.push_back(32'h100 | i);
        end
        bus_rd(32'h4, rd); chk("ovr_status", rd, 32'h7);
        for (int i = 0; i < 16; i++) rd_sb($sformatf("ovr_data%0d", i));
        bus_rd(32'h4, rd); chk("ovr_only", rd, 32'h4);
        bus_wr(32'h4, 32'h4);
        bus_rd(32'h4, rd); chk("ovr_cleared", rd, 32'h0);

        bus_wr(32'hC, 32'h5);
        send(8'hA3, 1'b0, 1'b1);
        bus_rd(32'h4, rd); chk("fe_status", rd, 32'h8);
        chk("fe_irq", {31'd0, irq}, 32'd1);
        bus_wr(32'h4, 32'h8);
        bus_rd(32'h4, rd); chk("fe_cleared", rd, 32'h0);
        chk("fe_irq_low", {31'd0, irq}, 32'd0);

        rx = 1'b0;
        repeat (20) @(posedge HCLK);
        #1 rx = 1'b1;
        repeat (200) @(posedge HCLK);
        #1;
        bus_rd(32'h4, rd); chk("glitch_status", rd, 32'h0);
        send(8'h3C, 1'b1, 1'b1); sb.push_back(32'h13C);
        rd_sb("glitch_next");

        rx = 1'b0; bitwait();
        rx = 1'b1;
        repeat (32) @(posedge HCLK);
        #1;
        bus_wr(32'hC, 32'h4);
        repeat (29) @(posedge HCLK);
        #1;
        for (int i = 1; i < 8; i++) begin
            rx = (i == 7);
            bitwait();
        end
        rx = 1'b1; bitwait(); bitwait();
        bus_rd(32'h4, rd); chk("abort_status", rd, 32'h0);
        bus_wr(32'hC, 32'h5);
        send(8'h3C, 1'b1, 1'b1); sb.push_back(32'h13C);
        bus_rd(32'h4, rd); chk("abort_rxne", rd, 32'h1);
        chk("rxne_irq", {31'd0, irq}, 32'd1);
        rd_sb("abort_data");
        bus_rd(32'h0, rd); chk("abort_empty", rd, 32'h0);

        send(8'hE1, 1'b1, 1'b1);
        bus_wr(32'hC, 32'h7);
        bus_rd(32'h4, rd); chk("flush_status", rd, 32'h0);
        bus_rd(32'hC, rd); chk("flush_ctrl", rd, 32'h5);

`ifdef UART_RX_PARITY_EN
        send(8'h07, 1'b1, 1'b0);
        bus_rd(32'h4, rd); chk("pe_status", rd, 32'h10);
        bus_wr(32'h4, 32'h10);
        bus_rd(32'h4, rd); chk("pe_cleared", rd, 32'h0);
        send(8'h07, 1'b1, 1'b1); sb.push_back(32'h107);
        rd_sb("pe_good_data");
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
